// File: rtl/soc_config_pkg.sv
// Shared SoC configuration types for the core data-port AXI bridge.
// FSM state encoding and fixed AXI field values.
package soc_config_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        B_WAIT = 3'd2,
        READ   = 3'd3,
        R_WAIT = 3'd4
    } core_data_bridge_state_e;

    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_bus.sv
// AXI4 bus bundle shared between masters, the crossbar and slaves.
// Master drives requests and response-ready; Slave is the mirror.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1
);

    logic [AXI_ID_WIDTH-1:0]     aw_id;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                  aw_len;
    logic [2:0]                  aw_size;
    logic [1:0]                  aw_burst;
    logic                        aw_lock;
    logic [3:0]                  aw_cache;
    logic [2:0]                  aw_prot;
    logic [3:0]                  aw_qos;
    logic [3:0]                  aw_region;
    logic [5:0]                  aw_atop;
    logic [AXI_USER_WIDTH-1:0]   aw_user;
    logic                        aw_valid;
    logic                        aw_ready;

    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_last;
    logic [AXI_USER_WIDTH-1:0]   w_user;
    logic                        w_valid;
    logic                        w_ready;

    logic [AXI_ID_WIDTH-1:0]     b_id;
    logic [1:0]                  b_resp;
    logic [AXI_USER_WIDTH-1:0]   b_user;
    logic                        b_valid;
    logic                        b_ready;

    logic [AXI_ID_WIDTH-1:0]     ar_id;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                  ar_len;
    logic [2:0]                  ar_size;
    logic [1:0]                  ar_burst;
    logic                        ar_lock;
    logic [3:0]                  ar_cache;
    logic [2:0]                  ar_prot;
    logic [3:0]                  ar_qos;
    logic [3:0]                  ar_region;
    logic [AXI_USER_WIDTH-1:0]   ar_user;
    logic                        ar_valid;
    logic                        ar_ready;

    logic [AXI_ID_WIDTH-1:0]     r_id;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_last;
    logic [AXI_USER_WIDTH-1:0]   r_user;
    logic                        r_valid;
    logic                        r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
        output aw_cache, aw_prot, aw_qos, aw_region, aw_atop, aw_user,
        output aw_valid, input aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
        input b_id, b_resp, b_user, b_valid, output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
        output ar_cache, ar_prot, ar_qos, ar_region, ar_user,
        output ar_valid, input ar_ready,
        input r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock,
        input aw_cache, aw_prot, aw_qos, aw_region, aw_atop, aw_user,
        input aw_valid, output aw_ready,
        input w_data, w_strb, w_last, w_user, w_valid, output w_ready,
        output b_id, b_resp, b_user, b_valid, input b_ready,
        input ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock,
        input ar_cache, ar_prot, ar_qos, ar_region, ar_user,
        input ar_valid, output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input r_ready
    );

endinterface

// File: rtl/core_data_axi_bridge.sv
// CV32E40P OBI data port to single-beat AXI4 master, one outstanding access.
// Response pulse and read data are registered one cycle after B/R handshake.
module core_data_axi_bridge #(
    parameter int unsigned AxiAddrWidth = 32,
    parameter int unsigned AxiDataWidth = 32,
    parameter int unsigned AxiIdWidth   = 4,
    parameter int unsigned AxiUserWidth = 1,
    parameter int unsigned AxiId        = 0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    AXI_BUS.Master      axi_mst
);

    import soc_config_pkg::*;

    if (AxiAddrWidth != 32 || AxiDataWidth != 32 || AxiUserWidth == 0)
    begin : g_param_err
        $error("core_data_axi_bridge: AXI address/data width must be 32");
    end

    core_data_bridge_state_e r_state;
    core_data_bridge_state_e w_state_next;

    logic [AxiAddrWidth-1:0] r_addr;
    logic                    r_we;
    logic [3:0]              r_be;
    logic [31:0]             r_wdata;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic                    r_rvalid;
    logic                    r_err;
    logic [31:0]             r_rdata;

    logic w_accept;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_r_hs;
    logic w_aw_valid;
    logic w_w_valid;
    logic w_ar_valid;
    logic w_b_ready;
    logic w_r_ready;
    logic w_unused;

    assign w_accept = (r_state == IDLE) & data_req_i;
    assign w_aw_hs  = (r_state == WRITE) & ~r_aw_done & axi_mst.aw_ready;
    assign w_w_hs   = (r_state == WRITE) & ~r_w_done & axi_mst.w_ready;
    assign w_b_hs   = (r_state == B_WAIT) & axi_mst.b_valid;
    assign w_r_hs   = (r_state == R_WAIT) & axi_mst.r_valid;

    // While a channel is not yet done its valid is high, so ready alone
    // means handshake; this keeps the next-state logic off the valids.
    always_comb begin
        w_state_next = r_state;
        data_gnt_o   = 1'b0;
        w_aw_valid   = 1'b0;
        w_w_valid    = 1'b0;
        w_ar_valid   = 1'b0;
        w_b_ready    = 1'b0;
        w_r_ready    = 1'b0;
        unique case (r_state)
            IDLE: begin
                data_gnt_o = data_req_i;
                if (data_req_i) begin
                    w_state_next = data_we_i ? WRITE : READ;
                end
            end
            WRITE: begin
                w_aw_valid = ~r_aw_done;
                w_w_valid  = ~r_w_done;
                if ((r_aw_done | axi_mst.aw_ready) &&
                    (r_w_done | axi_mst.w_ready)) begin
                    w_state_next = B_WAIT;
                end
            end
            B_WAIT: begin
                w_b_ready = 1'b1;
                if (axi_mst.b_valid) w_state_next = IDLE;
            end
            READ: begin
                w_ar_valid = 1'b1;
                if (axi_mst.ar_ready) w_state_next = R_WAIT;
            end
            R_WAIT: begin
                w_r_ready = 1'b1;
                if (axi_mst.r_valid) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_rvalid <= w_b_hs | w_r_hs;
            if (w_accept) begin
                r_addr    <= data_addr_i;
                r_we      <= data_we_i;
                r_be      <= data_be_i;
                r_wdata   <= data_wdata_i;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
            end
            if (w_b_hs | w_r_hs) begin
                r_err   <= r_we ? (axi_mst.b_resp != AXI_RESP_OKAY)
                                : (axi_mst.r_resp != AXI_RESP_OKAY);
                r_rdata <= r_we ? '0 : axi_mst.r_data;
            end
        end
    end

    assign data_rvalid_o = r_rvalid;
    assign data_rdata_o  = r_rdata;
    assign data_err_o    = r_err;

    assign axi_mst.aw_id     = AxiIdWidth'(AxiId);
    assign axi_mst.aw_addr   = r_addr;
    assign axi_mst.aw_len    = '0;
    assign axi_mst.aw_size   = AXI_SIZE_WORD;
    assign axi_mst.aw_burst  = AXI_BURST_INCR;
    assign axi_mst.aw_lock   = 1'b0;
    assign axi_mst.aw_cache  = '0;
    assign axi_mst.aw_prot   = '0;
    assign axi_mst.aw_qos    = '0;
    assign axi_mst.aw_region = '0;
    assign axi_mst.aw_atop   = '0;
    assign axi_mst.aw_user   = '0;
    assign axi_mst.aw_valid  = w_aw_valid;

    assign axi_mst.w_data    = r_wdata;
    assign axi_mst.w_strb    = r_be;
    assign axi_mst.w_last    = 1'b1;
    assign axi_mst.w_user    = '0;
    assign axi_mst.w_valid   = w_w_valid;

    assign axi_mst.b_ready   = w_b_ready;

    assign axi_mst.ar_id     = AxiIdWidth'(AxiId);
    assign axi_mst.ar_addr   = r_addr;
    assign axi_mst.ar_len    = '0;
    assign axi_mst.ar_size   = AXI_SIZE_WORD;
    assign axi_mst.ar_burst  = AXI_BURST_INCR;
    assign axi_mst.ar_lock   = 1'b0;
    assign axi_mst.ar_cache  = '0;
    assign axi_mst.ar_prot   = '0;
    assign axi_mst.ar_qos    = '0;
    assign axi_mst.ar_region = '0;
    assign axi_mst.ar_user   = '0;
    assign axi_mst.ar_valid  = w_ar_valid;

    assign axi_mst.r_ready   = w_r_ready;

    // Single-beat, single-ID traffic: returned IDs/last/user carry no info.
    assign w_unused = ^{axi_mst.b_id, axi_mst.b_user, axi_mst.r_id,
                        axi_mst.r_last, axi_mst.r_user};

endmodule

// File: tb/tb_core_data_axi_bridge.sv
// Directed bench for core_data_axi_bridge with an AXI slave model
// and a response scoreboard.
module tb_core_data_axi_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    always #5 clk = ~clk;

    AXI_BUS #(
        .AXI_ADDR_WIDTH(32),
        .AXI_DATA_WIDTH(32),
        .AXI_ID_WIDTH(4),
        .AXI_USER_WIDTH(1)
    ) bus ();

    core_data_axi_bridge #(
        .AxiAddrWidth(32),
        .AxiDataWidth(32),
        .AxiIdWidth(4),
        .AxiUserWidth(1),
        .AxiId(0)
    ) dut (
        .clk_i(clk),
        .reset_i(rst),
        .data_req_i(req),
        .data_gnt_o(gnt),
        .data_we_i(we),
        .data_be_i(be),
        .data_addr_i(addr),
        .data_wdata_i(wdata),
        .data_rvalid_o(rvalid),
        .data_rdata_o(rdata),
        .data_err_o(err),
        .axi_mst(bus)
    );

    int checks = 0;
    int failures = 0;

    // slave model knobs and capture
    int aw_dly = 0, w_dly = 0, ar_dly = 0;
    bit r_hold = 1'b0;
    int aw_wait = 0, w_wait = 0, ar_wait = 0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    logic got_aw, got_w, ar_pend;
    logic [31:0] c_aw_addr, c_ar_addr, c_w_data;
    logic [3:0]  c_w_strb, c_aw_id, c_ar_id;
    logic        c_w_last;
    logic [2:0]  c_aw_size, c_ar_size;
    logic [7:0]  c_aw_len, c_ar_len;
    logic [1:0]  c_aw_burst, c_ar_burst;
    logic [1:0]  b_resp_q, r_resp_q;
    logic [31:0] r_data_q;
    logic        b_valid_q, r_valid_q;

    function automatic logic [1:0] wr_resp(input logic [31:0] a);
        return (a == 32'h0000_3000) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [1:0] rd_resp(input logic [31:0] a);
        return (a[31:16] == 16'hDEAD) ? 2'b11 : 2'b00;
    endfunction

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        if (a == 32'h0000_2000) return 32'hDEAD_BEEF;
        if (a[31:16] == 16'hDEAD) return 32'hBAD0_0000;
        return a ^ 32'hA5A5_0000;
    endfunction

    assign bus.aw_ready = bus.aw_valid && (aw_wait >= aw_dly);
    assign bus.w_ready  = bus.w_valid && (w_wait >= w_dly);
    assign bus.ar_ready = bus.ar_valid && (ar_wait >= ar_dly);
    assign bus.b_valid  = b_valid_q;
    assign bus.b_resp   = b_resp_q;
    assign bus.b_id     = '0;
    assign bus.b_user   = '0;
    assign bus.r_valid  = r_valid_q;
    assign bus.r_resp   = r_resp_q;
    assign bus.r_data   = r_data_q;
    assign bus.r_id     = '0;
    assign bus.r_user   = '0;
    assign bus.r_last   = 1'b1;

    wire aw_hs = bus.aw_valid && bus.aw_ready;
    wire w_hs  = bus.w_valid && bus.w_ready;
    wire ar_hs = bus.ar_valid && bus.ar_ready;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_wait   <= 0;
            w_wait    <= 0;
            ar_wait   <= 0;
            got_aw    <= 1'b0;
            got_w     <= 1'b0;
            ar_pend   <= 1'b0;
            b_valid_q <= 1'b0;
            r_valid_q <= 1'b0;
            b_resp_q  <= 2'b00;
            r_resp_q  <= 2'b00;
            r_data_q  <= 32'h0;
        end else begin
            aw_wait <= (bus.aw_valid && !bus.aw_ready) ? aw_wait + 1 : 0;
            w_wait  <= (bus.w_valid && !bus.w_ready) ? w_wait + 1 : 0;
            ar_wait <= (bus.ar_valid && !bus.ar_ready) ? ar_wait + 1 : 0;
            if (aw_hs) begin
                got_aw     <= 1'b1;
                aw_cnt     <= aw_cnt + 1;
                c_aw_addr  <= bus.aw_addr;
                c_aw_size  <= bus.aw_size;
                c_aw_len   <= bus.aw_len;
                c_aw_burst <= bus.aw_burst;
                c_aw_id    <= bus.aw_id;
            end
            if (w_hs) begin
                got_w    <= 1'b1;
                w_cnt    <= w_cnt + 1;
                c_w_data <= bus.w_data;
                c_w_strb <= bus.w_strb;
                c_w_last <= bus.w_last;
            end
            if (b_valid_q && bus.b_ready) begin
                b_valid_q <= 1'b0;
            end else if (!b_valid_q && (got_aw || aw_hs) && (got_w || w_hs)) begin
                b_valid_q <= 1'b1;
                b_resp_q  <= wr_resp(aw_hs ? bus.aw_addr : c_aw_addr);
                got_aw    <= 1'b0;
                got_w     <= 1'b0;
            end
            if (ar_hs) begin
                ar_pend    <= 1'b1;
                ar_cnt     <= ar_cnt + 1;
                c_ar_addr  <= bus.ar_addr;
                c_ar_size  <= bus.ar_size;
                c_ar_len   <= bus.ar_len;
                c_ar_burst <= bus.ar_burst;
                c_ar_id    <= bus.ar_id;
            end
            if (r_valid_q && bus.r_ready) begin
                r_valid_q <= 1'b0;
            end else if (!r_valid_q && (ar_pend || ar_hs) && !r_hold) begin
                r_valid_q <= 1'b1;
                r_data_q  <= rd_val(ar_hs ? bus.ar_addr : c_ar_addr);
                r_resp_q  <= rd_resp(ar_hs ? bus.ar_addr : c_ar_addr);
                ar_pend   <= 1'b0;
            end
        end
    end

    // scoreboard and monitor
    typedef struct {
        logic [31:0] rd;
        logic        e;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int cyc = 0;
    int gnt_cyc = 0, gnt_cnt = 0, rv_cnt = 0;
    int bad_gnt = 0, proto_err = 0;
    bit wr_aw_seen = 1'b0, wr_w_seen = 1'b0;
    bit p_awv = 1'b0, p_wv = 1'b0, p_arv = 1'b0;
    logic [31:0] p_awa, p_wd, p_ara;
    logic [3:0]  p_ws;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            p_awv = 1'b0;
            p_wv  = 1'b0;
            p_arv = 1'b0;
        end else begin
            if (rvalid) begin
                rv_cnt++;
                checks++;
                assert (sb.size() != 0) else begin
                    failures++;
                    $error("FAIL sb_underflow got=0 want=nonzero");
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    checks++;
                    assert (rdata === e.rd) else begin
                        failures++;
                        $error("FAIL rdata got=%h want=%h", rdata, e.rd);
                    end
                    checks++;
                    assert (err === e.e) else begin
                        failures++;
                        $error("FAIL err got=%0b want=%0b", err, e.e);
                    end
                    if (e.lat != 0) begin
                        checks++;
                        assert ((cyc - gnt_cyc) == e.lat) else begin
                            failures++;
                            $error("FAIL latency got=%0d want=%0d",
                                   cyc - gnt_cyc, e.lat);
                        end
                    end
                end
            end
            if (rvalid && req && !gnt) bad_gnt++;
            if (gnt) begin
                if (bus.aw_valid || bus.w_valid || bus.ar_valid ||
                    bus.b_ready || bus.r_ready) bad_gnt++;
                gnt_cnt++;
                gnt_cyc = cyc;
                wr_aw_seen = 1'b0;
                wr_w_seen  = 1'b0;
            end
            if (bus.b_ready && !(wr_aw_seen && wr_w_seen)) proto_err++;
            if (aw_hs) wr_aw_seen = 1'b1;
            if (w_hs) wr_w_seen = 1'b1;
            if (p_awv && (!bus.aw_valid || bus.aw_addr !== p_awa)) proto_err++;
            if (p_wv && (!bus.w_valid || bus.w_data !== p_wd ||
                         bus.w_strb !== p_ws)) proto_err++;
            if (p_arv && (!bus.ar_valid || bus.ar_addr !== p_ara)) proto_err++;
            p_awv = bus.aw_valid && !bus.aw_ready;
            p_wv  = bus.w_valid && !bus.w_ready;
            p_arv = bus.ar_valid && !bus.ar_ready;
            p_awa = bus.aw_addr;
            p_wd  = bus.w_data;
            p_ws  = bus.w_strb;
            p_ara = bus.ar_addr;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // called just after a posedge; returns just after the accepting posedge
    task automatic issue(input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d,
                         input int lat);
        exp_t x;
        bit ok;
        x.rd  = w ? 32'h0 : rd_val(a);
        x.e   = w ? (wr_resp(a) != 2'b00) : (rd_resp(a) != 2'b00);
        x.lat = lat;
        sb.push_back(x);
        req   = 1'b1;
        we    = w;
        addr  = a;
        be    = b;
        wdata = d;
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (gnt) begin
                ok = 1'b1;
                break;
            end
        end
        chk("grant_wait", {63'd0, ok}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    int aw0, w0, g0, r0;
    bit seen;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", {63'd0, gnt}, 64'd0);
        chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_rdata", {32'd0, rdata}, 64'd0);
        chk("rst_valids", {59'd0, bus.aw_valid, bus.w_valid, bus.ar_valid,
                           bus.b_ready, bus.r_ready}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // plain read
        issue(1'b0, 32'h0000_2000, 4'hF, 32'h0, 3);
        drain();
        chk("ar_addr", {32'd0, c_ar_addr}, 64'h2000);
        chk("ar_size", {61'd0, c_ar_size}, 64'd2);
        chk("ar_len", {56'd0, c_ar_len}, 64'd0);
        chk("ar_burst", {62'd0, c_ar_burst}, 64'd1);
        chk("ar_id", {60'd0, c_ar_id}, 64'd0);

        // plain write
        aw0 = aw_cnt;
        w0  = w_cnt;
        issue(1'b1, 32'h0000_2004, 4'b0011, 32'h1234_5678, 3);
        drain();
        chk("aw_addr", {32'd0, c_aw_addr}, 64'h2004);
        chk("w_strb", {60'd0, c_w_strb}, 64'h3);
        chk("w_data", {32'd0, c_w_data}, 64'h1234_5678);
        chk("w_last", {63'd0, c_w_last}, 64'd1);
        chk("aw_size", {61'd0, c_aw_size}, 64'd2);
        chk("aw_len", {56'd0, c_aw_len}, 64'd0);
        chk("aw_burst", {62'd0, c_aw_burst}, 64'd1);
        chk("aw_cnt1", 64'(aw_cnt - aw0), 64'd1);
        chk("w_cnt1", 64'(w_cnt - w0), 64'd1);

        // AW ready late, then W ready late
        aw_dly = 3;
        aw0 = aw_cnt;
        w0  = w_cnt;
        issue(1'b1, 32'h0000_2008, 4'hF, 32'hCAFE_F00D, 6);
        drain();
        chk("aw_cnt_awdly", 64'(aw_cnt - aw0), 64'd1);
        chk("w_cnt_awdly", 64'(w_cnt - w0), 64'd1);
        chk("w_data_awdly", {32'd0, c_w_data}, 64'hCAFE_F00D);
        aw_dly = 0;
        w_dly  = 3;
        aw0 = aw_cnt;
        w0  = w_cnt;
        issue(1'b1, 32'h0000_200C, 4'b1100, 32'h0BAD_CAFE, 6);
        drain();
        chk("aw_cnt_wdly", 64'(aw_cnt - aw0), 64'd1);
        chk("w_cnt_wdly", 64'(w_cnt - w0), 64'd1);
        chk("aw_addr_wdly", {32'd0, c_aw_addr}, 64'h200C);
        w_dly = 0;

        // error responses, then recovery; slow AR
        issue(1'b0, 32'hDEAD_0000, 4'hF, 32'h0, 3);
        drain();
        issue(1'b0, 32'h0000_2010, 4'hF, 32'h0, 3);
        drain();
        issue(1'b1, 32'h0000_3000, 4'hF, 32'h5555_AAAA, 3);
        drain();
        ar_dly = 2;
        issue(1'b0, 32'h0000_2014, 4'hF, 32'h0, 5);
        drain();
        ar_dly = 0;

        // continuous requests, alternating read/write
        g0 = gnt_cnt;
        r0 = rv_cnt;
        issue(1'b0, 32'h0000_2100, 4'hF, 32'h0, 3);
        issue(1'b1, 32'h0000_2104, 4'hF, 32'h1111_2222, 3);
        issue(1'b0, 32'h0000_2108, 4'hF, 32'h0, 3);
        issue(1'b1, 32'h0000_210C, 4'h1, 32'h3333_4444, 3);
        issue(1'b0, 32'h0000_2110, 4'hF, 32'h0, 3);
        drain();
        chk("cont_gnts", 64'(gnt_cnt - g0), 64'd5);
        chk("cont_rvalids", 64'(rv_cnt - r0), 64'd5);

        // reset while waiting on R, after an errored read left state set
        issue(1'b0, 32'hDEAD_0004, 4'hF, 32'h0, 3);
        drain();
        r_hold = 1'b1;
        issue(1'b0, 32'h0000_2200, 4'hF, 32'h0, 0);
        req  = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.r_ready) begin
                seen = 1'b1;
                break;
            end
        end
        chk("r_wait_reached", {63'd0, seen}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_r_ready", {63'd0, bus.r_ready}, 64'd0);
        chk("mid_rst_err", {63'd0, err}, 64'd0);
        chk("mid_rst_rdata", {32'd0, rdata}, 64'd0);
        chk("mid_rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("mid_rst_gnt", {63'd0, gnt}, 64'd0);
        sb.delete();
        r_hold = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue(1'b0, 32'h0000_2204, 4'hF, 32'h0, 3);
        drain();

        chk("bad_grants", 64'(bad_gnt), 64'd0);
        chk("protocol", 64'(proto_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
